// File: rtl/imem_boot_loader_if.sv
// Bundle of boot-stream, instruction-memory and fetch-path signals around the boot loader.
// The slave modport is the loader's view; the master modport is the surrounding system.
interface imem_boot_loader_if #(
    parameter int unsigned AW = 10
) ();
    logic          start;
    logic [AW:0]   len;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   fetch_addr;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic [31:0]   fetch_instr;
    logic          core_rst_n;
    logic          busy;
    logic          err;

    modport slave (
        input  start, len, s_valid, s_data, fetch_addr, mem_rdata,
        output s_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, fetch_instr,
        output core_rst_n, busy, err
    );

    modport master (
        output start, len, s_valid, s_data, fetch_addr, mem_rdata,
        input  s_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, fetch_instr,
        input  core_rst_n, busy, err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: assembles little-endian words from a byte stream, writes them
// into the instruction store, then releases the core and opens the fetch path.
module imem_boot_loader #(
    parameter int unsigned AW     = 10,
    parameter int unsigned MAXLEN = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst,   // active-low, asynchronous
    imem_boot_loader_if.slave  bus
);

    localparam logic [AW:0] LP_MAXLEN = (AW+1)'(MAXLEN);
    localparam logic [AW:0] LP_ONE    = (AW+1)'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_e;

    state_e        r_state,      w_state;
    logic [AW:0]   r_len,        w_len;
    logic [AW:0]   r_word_cnt,   w_word_cnt;
    logic [1:0]    r_byte_cnt,   w_byte_cnt;
    logic [31:0]   r_word,       w_word;
    logic          r_mem_we,     w_mem_we;
    logic [AW-1:0] r_mem_waddr,  w_mem_waddr;
    logic [31:0]   r_mem_wdata,  w_mem_wdata;
    logic          r_err,        w_err;
    logic          r_core_rst_n, w_core_rst_n;
    logic [31:0]   w_word_asm;
    logic          w_aligned;
    logic          w_unused_addr;

    // Upper PC bits are deliberately ignored: the store wraps modulo its depth.
    assign w_unused_addr = ^bus.fetch_addr[31:AW+2];
    assign w_aligned     = (bus.fetch_addr[1:0] == 2'b00);

    // Next-state logic: start handling, byte assembly, word writes and fetch error detection.
    always_comb begin
        w_state      = r_state;
        w_len        = r_len;
        w_word_cnt   = r_word_cnt;
        w_byte_cnt   = r_byte_cnt;
        w_word       = r_word;
        w_mem_we     = 1'b0;
        w_mem_waddr  = r_mem_waddr;
        w_mem_wdata  = r_mem_wdata;
        w_err        = r_err;
        w_core_rst_n = 1'b0;

        // Current partial word with the incoming byte dropped into its lane.
        w_word_asm = r_word;
        unique case (r_byte_cnt)
            2'd0: w_word_asm[7:0]   = bus.s_data;
            2'd1: w_word_asm[15:8]  = bus.s_data;
            2'd2: w_word_asm[23:16] = bus.s_data;
            2'd3: w_word_asm[31:24] = bus.s_data;
            default: ;
        endcase

        case (r_state)
            StIdle, StRun: begin
                if (r_state == StRun) begin
                    w_core_rst_n = 1'b1;
                    if (!w_aligned) begin
                        w_err = 1'b1;
                    end
                end
                // A start (load or reload) always puts the core back into reset first.
                if (bus.start) begin
                    w_core_rst_n = 1'b0;
                    w_len        = bus.len;
                    if (bus.len == '0) begin
                        w_state = StRun;
                        w_err   = 1'b0;
                    end else if (bus.len > LP_MAXLEN) begin
                        w_state = StIdle;
                        w_err   = 1'b1;
                    end else begin
                        w_state    = StLoad;
                        w_word_cnt = '0;
                        w_byte_cnt = 2'd0;
                        w_word     = '0;
                        w_err      = 1'b0;
                    end
                end
            end
            StLoad: begin
                if (bus.s_valid) begin
                    w_word     = w_word_asm;
                    w_byte_cnt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_mem_we    = 1'b1;
                        w_mem_waddr = r_word_cnt[AW-1:0];
                        w_mem_wdata = w_word_asm;
                        w_word_cnt  = r_word_cnt + LP_ONE;
                        // Leave LOAD together with the final write so s_ready drops with it.
                        if ((r_word_cnt + LP_ONE) == r_len) begin
                            w_state = StRun;
                        end
                    end
                end
            end
            default: w_state = StIdle;
        endcase
    end

    // State and output registers; reset abandons any partial word.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= StIdle;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_byte_cnt   <= 2'd0;
            r_word       <= '0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_len        <= w_len;
            r_word_cnt   <= w_word_cnt;
            r_byte_cnt   <= w_byte_cnt;
            r_word       <= w_word;
            r_mem_we     <= w_mem_we;
            r_mem_waddr  <= w_mem_waddr;
            r_mem_wdata  <= w_mem_wdata;
            r_err        <= w_err;
            r_core_rst_n <= w_core_rst_n;
        end
    end

    assign bus.s_ready     = (r_state == StLoad);
    assign bus.busy        = (r_state == StLoad);
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_waddr   = r_mem_waddr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_raddr   = bus.fetch_addr[AW+1:2];
    assign bus.fetch_instr = ((r_state == StRun) && w_aligned) ? bus.mem_rdata : 32'h0;
    assign bus.core_rst_n  = r_core_rst_n;
    assign bus.err         = r_err;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences the instruction memory: loads a program from a byte-stream boot port into the 1024x32 word-addressed instruction store, then releases the core.
- Sits between the boot link/UART receiver, the instruction memory and the core fetch path.
- Owns the memory write port.
- Gates the fetch read path so the core sees 32'h0 and is held in reset until a load completes.

Parameters:
- AW, 10, word-address width; memory depth is 2**AW words.
- MAXLEN, 1024, maximum load length in words; must be <= 2**AW.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load of len words.
- len  input  AW+1  word count, sampled only on an accepted start.
- s_valid  input  1  boot byte valid.
- s_data  input  8  boot byte.
- s_ready  output  1  boot byte accepted when s_valid & s_ready.
- mem_we  output  1  instruction memory write enable.
- mem_waddr  output  AW  write word address.
- mem_wdata  output  32  write data.
- fetch_addr  input  32  core PC (byte address).
- mem_raddr  output  AW  read word address = fetch_addr[AW+1:2], combinational.
- mem_rdata  input  32  memory read data (combinational read).
- fetch_instr  output  32  instruction to core.
- core_rst_n  output  1  core reset, active-low.
- busy  output  1  high in LOAD.
- err  output  1  sticky error flag.

Behaviour:
- Reset values: state IDLE; s_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, core_rst_n=0, busy=0, err=0; byte counter and word counter 0.
- FSM states IDLE, LOAD, RUN.
- IDLE:
  - core_rst_n=0; fetch_instr=0.
  - On start: latch len.
  - len==0 -> RUN.
  - len>MAXLEN -> set err, stay IDLE.
  - Otherwise -> LOAD; clear word counter and byte counter; clear err.
- LOAD:
  - busy=1, s_ready=1, core_rst_n=0, fetch_instr=0.
  - Each accepted byte fills lane byte_cnt (little-endian: first byte -> [7:0], fourth -> [31:24]).
  - byte_cnt wraps 3->0.
  - On the 4th byte accepted in cycle N, the following hold in cycle N+1:
    - mem_we=1 for exactly one cycle;
    - mem_waddr = word counter value before increment;
    - mem_wdata = assembled word.
  - The word counter increments in cycle N+1.
  - s_valid low stalls with no state change; partial words are retained indefinitely.
  - When the written word count equals len: in the cycle of the last mem_we, state -> RUN and s_ready drops to 0.
  - core_rst_n=1 from cycle N+2. The last write always lands before the core leaves reset.
  - start during LOAD is ignored.
- RUN:
  - core_rst_n=1, s_ready=0, busy=0.
  - fetch_instr = mem_rdata.
  - fetch_addr[1:0]!=0 -> fetch_instr=0 and err set (sticky until the next accepted start).
  - start in RUN -> core_rst_n=0 in the next cycle, then the same len checks as IDLE (reload).
  - Bytes presented in RUN are not accepted.
- mem_raddr always tracks fetch_addr[AW+1:2]. Upper fetch_addr bits beyond AW+1 are ignored (address wraps modulo depth).
- Reset mid-load: immediate return to IDLE; words already written remain in memory; no partial word is written.
- Simultaneous start and s_valid in IDLE: the byte is not accepted (s_ready=0 that cycle); LOAD begins next cycle.

Test Plan:
- Reset, start with len=2, stream bytes 13 05 00 00 93 05 10 00 -> mem_we at addr 0 with data 32'h00000513, then addr 1 with data 32'h00100593; core_rst_n rises 2 cycles after the 8th byte; fetch_addr=4 gives fetch_instr=32'h00100593.
- Same load with s_valid toggled 1/0 every cycle -> identical writes; fetch_instr=0 and core_rst_n=0 throughout LOAD.
- start with len=0 -> RUN next cycle, no mem_we; start with len=1025 -> err=1, state stays IDLE, core_rst_n=0.
- In RUN, fetch_addr=32'h2 -> fetch_instr=0 and err=1; then start with len=1 -> err clears, core_rst_n=0, reload of word DEADBEEF writes addr 0.
- Assert rst low after 6 bytes of a len=2 load -> exactly one mem_we (addr 0) observed, all outputs at reset values, state IDLE.
- Full load of len=1024 with incrementing words -> last write at mem_waddr=1023; fetch_addr=32'hFFC returns word 1023; fetch_addr=32'h1000 wraps to word 0.
